// File: rtl/core_control_regs_pkg.sv
// Shared definitions for the core control register file: register indices,
// the per-cycle access kind and its decode helper.
package core_control_regs_pkg;

  localparam logic [4:0] CR_STRAND_ID = 5'd0;
  localparam logic [4:0] CR_CYCLE_LO  = 5'd1;
  localparam logic [4:0] CR_CYCLE_HI  = 5'd2;
  localparam logic [4:0] CR_TIMER     = 5'd3;
  localparam logic [4:0] CR_SCRATCH   = 5'd4;
  localparam logic [4:0] CR_IRQ_CLR   = 5'd5;
  localparam logic [4:0] CR_TEST      = 5'd7;
  localparam logic [4:0] CR_HALT_SELF = 5'd28;
  localparam logic [4:0] CR_RESUME    = 5'd29;
  localparam logic [4:0] CR_STRAND_EN = 5'd30;
  localparam logic [4:0] CR_HALT_ALL  = 5'd31;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } cr_access_e;

  // A simultaneous read and write is treated as a write; the read is dropped.
  function automatic cr_access_e cr_access(input logic read_en, input logic write_en);
    if (write_en) begin
      return ACC_WRITE;
    end else if (read_en) begin
      return ACC_READ;
    end else begin
      return ACC_IDLE;
    end
  endfunction

endpackage

// File: rtl/core_control_regs_if.sv
// Execute-stage access port of the control register file.
interface core_control_regs_if #(
  parameter int NUM_STRANDS = 4
);
  localparam int STRAND_IDX_W = $clog2(NUM_STRANDS);

  logic [STRAND_IDX_W-1:0] ex_strand;
  logic [4:0]              cr_index;
  logic                    cr_read_en;
  logic                    cr_write_en;
  logic [31:0]             cr_write_value;
  logic [31:0]             cr_read_value;

  modport master (
    output ex_strand,
    output cr_index,
    output cr_read_en,
    output cr_write_en,
    output cr_write_value,
    input  cr_read_value
  );

  modport slave (
    input  ex_strand,
    input  cr_index,
    input  cr_read_en,
    input  cr_write_en,
    input  cr_write_value,
    output cr_read_value
  );

endinterface

// File: rtl/core_control_regs_cr_timer.sv
// Countdown timer with a level interrupt: set on the 1->0 step, cleared on request.
module core_control_regs_cr_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        clear,
  output logic        irq,
  output logic [31:0] count
);

  logic [31:0] count_r;
  logic        irq_r;
  logic        expire_s;

  // A load at the same edge suppresses both the decrement and the expiry.
  assign expire_s = !load && (count_r == 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 32'd0;
      irq_r   <= 1'b0;
    end else begin
      if (load) begin
        count_r <= load_value;
      end else if (count_r != 32'd0) begin
        count_r <= count_r - 32'd1;
      end else begin
        count_r <= count_r;
      end
      // Expiry beats a clear landing on the same edge.
      if (expire_s) begin
        irq_r <= 1'b1;
      end else if (clear) begin
        irq_r <= 1'b0;
      end else begin
        irq_r <= irq_r;
      end
    end
  end

  assign count = count_r;
  assign irq   = irq_r;

endmodule

// File: rtl/core_control_regs.sv
// Per-core control register file: strand ID, scratch, 64-bit cycle counter with
// high-word shadow, countdown timer and strand enable/halt/resume.
module core_control_regs
  import core_control_regs_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int NUM_STRANDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  core_control_regs_if.slave     cr,
  output logic [NUM_STRANDS-1:0] strand_enable,
  output logic                   timer_irq,
  output logic                   core_halted
);

  localparam int STRAND_IDX_W = $clog2(NUM_STRANDS);
  localparam logic [NUM_STRANDS-1:0] EN_RESET = {{(NUM_STRANDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_STRANDS-1:0] EN_NONE  = {NUM_STRANDS{1'b0}};

  logic [63:0]             cycle_r;
  logic [31:0]             shadow_r;
  logic [31:0]             scratch_r [NUM_STRANDS];
  logic [31:0]             test_r;
  logic [31:0]             read_value_r;
  logic [NUM_STRANDS-1:0]  strand_enable_r;
  logic                    core_halted_r;

  cr_access_e              access_s;
  logic                    wr_s;
  logic                    rd_s;
  logic [31:0]             read_mux_s;
  logic [31:0]             strand_id_s;
  logic [31:0]             timer_count_s;
  logic [STRAND_IDX_W-1:0] strand_s;

  assign access_s    = cr_access(cr.cr_read_en, cr.cr_write_en);
  assign wr_s        = (access_s == ACC_WRITE);
  assign rd_s        = (access_s == ACC_READ);
  assign strand_s    = cr.ex_strand;
  assign strand_id_s = (32'(CORE_ID) << STRAND_IDX_W) | 32'(strand_s);

  core_control_regs_cr_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (wr_s && (cr.cr_index == CR_TIMER)),
    .load_value (cr.cr_write_value),
    .clear      (wr_s && (cr.cr_index == CR_IRQ_CLR)),
    .irq        (timer_irq),
    .count      (timer_count_s)
  );

  // Write-only and unmapped indices fall through to zero.
  always_comb begin
    read_mux_s = 32'd0;
    case (cr.cr_index)
      CR_STRAND_ID: read_mux_s = strand_id_s;
      CR_CYCLE_LO:  read_mux_s = cycle_r[31:0];
      CR_CYCLE_HI:  read_mux_s = shadow_r;
      CR_TIMER:     read_mux_s = timer_count_s;
      CR_SCRATCH:   read_mux_s = scratch_r[strand_s];
      CR_TEST:      read_mux_s = test_r;
      CR_STRAND_EN: read_mux_s = 32'(strand_enable_r);
      default:      read_mux_s = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_r      <= 64'd0;
      shadow_r     <= 32'd0;
      test_r       <= 32'd0;
      read_value_r <= 32'd0;
      for (int i = 0; i < NUM_STRANDS; i++) begin
        scratch_r[i] <= 32'd0;
      end
    end else begin
      cycle_r <= cycle_r + 64'd1;
      if (rd_s) begin
        read_value_r <= read_mux_s;
        // Snapshot the pre-increment high word alongside the returned low word.
        if (cr.cr_index == CR_CYCLE_LO) begin
          shadow_r <= cycle_r[63:32];
        end else begin
          shadow_r <= shadow_r;
        end
      end else begin
        read_value_r <= read_value_r;
        shadow_r     <= shadow_r;
      end
      if (wr_s && (cr.cr_index == CR_SCRATCH)) begin
        scratch_r[strand_s] <= cr.cr_write_value;
      end else begin
        scratch_r[strand_s] <= scratch_r[strand_s];
      end
      if (wr_s && (cr.cr_index == CR_TEST)) begin
        test_r <= cr.cr_write_value;
      end else begin
        test_r <= test_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      strand_enable_r <= EN_RESET;
      core_halted_r   <= 1'b0;
    end else begin
      core_halted_r <= (strand_enable_r == EN_NONE);
      if (wr_s) begin
        case (cr.cr_index)
          CR_HALT_SELF: strand_enable_r[strand_s] <= 1'b0;
          CR_RESUME:    strand_enable_r <= strand_enable_r | cr.cr_write_value[NUM_STRANDS-1:0];
          CR_STRAND_EN: strand_enable_r <= cr.cr_write_value[NUM_STRANDS-1:0];
          CR_HALT_ALL:  strand_enable_r <= EN_NONE;
          default:      strand_enable_r <= strand_enable_r;
        endcase
      end else begin
        strand_enable_r <= strand_enable_r;
      end
    end
  end

  assign cr.cr_read_value = read_value_r;
  assign strand_enable    = strand_enable_r;
  assign core_halted      = core_halted_r;

endmodule

// File: tb/tb_core_control_regs.sv
// Scoreboard bench for core_control_regs (CORE_ID=2, NUM_STRANDS=4).
module tb_core_control_regs;
  import core_control_regs_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] strand_enable;
  logic       timer_irq;
  logic       core_halted;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];

  core_control_regs_if #(.NUM_STRANDS(4)) bus ();

  core_control_regs #(.CORE_ID(2), .NUM_STRANDS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .cr            (bus.slave),
    .strand_enable (strand_enable),
    .timer_irq     (timer_irq),
    .core_halted   (core_halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.cr_read_en  = 1'b0;
    bus.cr_write_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [1:0] strand, input logic [31:0] val);
    @(negedge clk);
    bus.cr_index       = idx;
    bus.ex_strand      = strand;
    bus.cr_write_value = val;
    bus.cr_write_en    = 1'b1;
    bus.cr_read_en     = 1'b0;
    @(posedge clk);
    #1;
    bus.cr_write_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] idx, input logic [1:0] strand,
                    input logic [31:0] exp);
    @(negedge clk);
    bus.cr_index   = idx;
    bus.ex_strand  = strand;
    bus.cr_read_en = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.cr_read_en = 1'b0;
    check_eq(tag, bus.cr_read_value, exp_q.pop_front());
  endtask

  initial begin
    reset              = 1'b1;
    bus.ex_strand      = 2'd0;
    bus.cr_index       = 5'd0;
    bus.cr_read_en     = 1'b0;
    bus.cr_write_en    = 1'b0;
    bus.cr_write_value = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_rdval", bus.cr_read_value, 32'd0);
    check_eq("rst_en", 32'(strand_enable), 32'h1);
    check_eq("rst_irq", 32'(timer_irq), 32'd0);
    check_eq("rst_halted", 32'(core_halted), 32'd0);

    rd("cr0_id", CR_STRAND_ID, 2'd3, 32'h0000_000B);
    check_eq("cr0_en", 32'(strand_enable), 32'h1);
    idle();
    check_eq("rd_hold", bus.cr_read_value, 32'h0000_000B);

    // Timer: irq rises exactly 5 edges after the load edge.
    wr(CR_TIMER, 2'd0, 32'd5);
    check_eq("tmr_e0", 32'(timer_irq), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      idle();
      check_eq($sformatf("tmr_e%0d", i), 32'(timer_irq), (i == 5) ? 32'd1 : 32'd0);
    end
    wr(CR_IRQ_CLR, 2'd0, 32'd1);
    check_eq("tmr_clr", 32'(timer_irq), 32'd0);

    // Clear landing on the expiry edge loses to the set.
    wr(CR_TIMER, 2'd0, 32'd3);
    idle();
    idle();
    wr(CR_IRQ_CLR, 2'd0, 32'd1);
    check_eq("tmr_setwins", 32'(timer_irq), 32'd1);
    wr(CR_TIMER, 2'd0, 32'd0);
    check_eq("tmr_cr3_noclr", 32'(timer_irq), 32'd1);
    wr(CR_IRQ_CLR, 2'd0, 32'd0);
    check_eq("tmr_clr2", 32'(timer_irq), 32'd0);

    wr(CR_TIMER, 2'd0, 32'd10);
    rd("tmr_rd0", CR_TIMER, 2'd0, 32'd10);
    rd("tmr_rd1", CR_TIMER, 2'd0, 32'd9);
    wr(CR_TIMER, 2'd0, 32'd0);
    repeat (3) idle();
    rd("tmr_off", CR_TIMER, 2'd0, 32'd0);
    check_eq("tmr_off_irq", 32'(timer_irq), 32'd0);

    // Cycle counter low-word wrap and shadow snapshot.
    @(negedge clk);
    force dut.cycle_r = 64'h0000_0000_FFFF_FFFF;
    bus.cr_index   = CR_CYCLE_LO;
    bus.cr_read_en = 1'b1;
    exp_q.push_back(32'hFFFF_FFFF);
    #1;
    release dut.cycle_r;
    @(posedge clk);
    #1;
    bus.cr_read_en = 1'b0;
    check_eq("cyc_lo", bus.cr_read_value, exp_q.pop_front());
    rd("cyc_hi0", CR_CYCLE_HI, 2'd0, 32'd0);
    rd("cyc_lo_wrap", CR_CYCLE_LO, 2'd0, 32'd1);
    rd("cyc_hi1", CR_CYCLE_HI, 2'd0, 32'd1);
    wr(CR_CYCLE_HI, 2'd0, 32'hDEAD_BEEF);
    rd("ro_ignored", CR_CYCLE_HI, 2'd0, 32'd1);

    // Strand control.
    wr(CR_STRAND_EN, 2'd0, 32'hF);
    check_eq("en_all", 32'(strand_enable), 32'hF);
    wr(CR_HALT_SELF, 2'd0, 32'd0);
    check_eq("halt_s0", 32'(strand_enable), 32'hE);
    wr(CR_HALT_SELF, 2'd1, 32'd0);
    check_eq("halt_s1", 32'(strand_enable), 32'hC);
    wr(CR_HALT_SELF, 2'd2, 32'd0);
    check_eq("halt_s2", 32'(strand_enable), 32'h8);
    wr(CR_HALT_SELF, 2'd3, 32'd0);
    check_eq("halt_s3", 32'(strand_enable), 32'h0);
    check_eq("halted_lag", 32'(core_halted), 32'd0);
    idle();
    check_eq("halted", 32'(core_halted), 32'd1);
    rd("en_rd0", CR_STRAND_EN, 2'd0, 32'd0);
    wr(CR_RESUME, 2'd0, 32'h5);
    check_eq("resume", 32'(strand_enable), 32'h5);
    idle();
    check_eq("unhalted", 32'(core_halted), 32'd0);
    rd("en_rd5", CR_STRAND_EN, 2'd0, 32'h5);
    wr(CR_HALT_ALL, 2'd0, 32'd0);
    check_eq("halt_all", 32'(strand_enable), 32'h0);

    // Scratch, test register, unmapped indices.
    wr(CR_SCRATCH, 2'd1, 32'hA5A5_A5A5);
    rd("scr_s2", CR_SCRATCH, 2'd2, 32'd0);
    rd("scr_s1", CR_SCRATCH, 2'd1, 32'hA5A5_A5A5);
    wr(CR_TEST, 2'd0, 32'h1234_5678);
    rd("test_rd", CR_TEST, 2'd0, 32'h1234_5678);
    rd("unmapped6", 5'd6, 2'd0, 32'd0);
    rd("wo_31", CR_HALT_ALL, 2'd0, 32'd0);

    // Read and write together: write lands, read value holds.
    @(negedge clk);
    bus.cr_index       = CR_TEST;
    bus.cr_write_value = 32'h0000_CAFE;
    bus.cr_write_en    = 1'b1;
    bus.cr_read_en     = 1'b1;
    @(posedge clk);
    #1;
    bus.cr_write_en = 1'b0;
    bus.cr_read_en  = 1'b0;
    check_eq("rw_hold", bus.cr_read_value, 32'd0);
    rd("rw_wrote", CR_TEST, 2'd0, 32'h0000_CAFE);

    // Reset mid-countdown with all strands halted.
    wr(CR_TIMER, 2'd0, 32'd5);
    idle();
    idle();
    check_eq("pre_rst_halted", 32'(core_halted), 32'd1);
    rd("pre_rst_cnt", CR_TIMER, 2'd0, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst2_rdval", bus.cr_read_value, 32'd0);
    check_eq("rst2_en", 32'(strand_enable), 32'h1);
    check_eq("rst2_irq", 32'(timer_irq), 32'd0);
    check_eq("rst2_halted", 32'(core_halted), 32'd0);
    rd("rst2_cnt", CR_TIMER, 2'd0, 32'd0);
    rd("rst2_test", CR_TEST, 2'd0, 32'd0);
    rd("rst2_scr", CR_SCRATCH, 2'd1, 32'd0);
    repeat (6) idle();
    check_eq("rst2_irq_late", 32'(timer_irq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
